// File: rtl/kovacs_sequencer.sv
// Multi-phase feedback sequencer: gates data_i[15:2] to data_o through up to four timed phases.
// Optional define KOVACS_SEQ_HOLD_EN turns mode 2'b10 into a hold phase (otherwise it acts as zero).
module kovacs_sequencer #(
  parameter int CNT_W = 32,
  parameter int CYC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      data_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] T0_i,
  input  logic [CNT_W-1:0] T1_i,
  input  logic [CNT_W-1:0] T2_i,
  input  logic [CNT_W-1:0] T3_i,
  input  logic [7:0]       mode_i,
  input  logic [1:0]       n_phases_i,
  input  logic [CYC_W-1:0] n_cycles_i,
  output logic [13:0]      data_o,
  output logic [13:0]      indicator_o,
  output logic [1:0]       phase_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] t_q [4];
  logic [7:0]       mode_q;
  logic [1:0]       nph_q;
  logic [CYC_W-1:0] ncyc_q;
  logic [CNT_W-1:0] ph_cnt;
  logic [1:0]       phase;
  logic [CYC_W-1:0] cyc_cnt;

  logic             ph_end, last_phase, finish;
  logic [CYC_W-1:0] cyc_inc;
  logic [1:0]       mode_cur;
  logic             unused_lsbs;

  assign unused_lsbs = ^data_i[1:0];
  assign state_o     = state;
  assign busy_o      = (state == ARM) || (state == RUN);

  // Equality compare keeps Tk = all-ones safe: the counter never steps past Tk.
  assign ph_end     = (ph_cnt == t_q[phase]);
  assign last_phase = (phase == nph_q);
  assign cyc_inc    = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
  assign finish     = ph_end && last_phase && (|ncyc_q) && (cyc_inc == ncyc_q);

  always_comb begin
    mode_cur = 2'b00;
    case (phase)
      2'd0: mode_cur = mode_q[1:0];
      2'd1: mode_cur = mode_q[3:2];
      2'd2: mode_cur = mode_q[5:4];
      2'd3: mode_cur = mode_q[7:6];
      default: mode_cur = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i && !stop_i) state_nxt = ARM;
      ARM:  state_nxt = stop_i ? IDLE : RUN;
      RUN:  begin
        if (stop_i)      state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) t_q[i] <= '0;
      mode_q  <= '0;
      nph_q   <= '0;
      ncyc_q  <= '0;
      ph_cnt  <= '0;
      phase   <= '0;
      cyc_cnt <= '0;
    end else if (state == ARM) begin
      t_q[0]  <= T0_i;
      t_q[1]  <= T1_i;
      t_q[2]  <= T2_i;
      t_q[3]  <= T3_i;
      mode_q  <= mode_i;
      nph_q   <= n_phases_i;
      ncyc_q  <= n_cycles_i;
      ph_cnt  <= '0;
      phase   <= '0;
      cyc_cnt <= '0;
    end else if (state == RUN) begin
      if (ph_end) begin
        ph_cnt <= '0;
        if (last_phase) begin
          phase   <= '0;
          cyc_cnt <= cyc_inc;
        end else begin
          phase <= phase + 2'd1;
        end
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  // Output registers show the result of the phase active one cycle earlier.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != RUN || stop_i) begin
      data_o      <= '0;
      indicator_o <= '0;
      phase_o     <= '0;
    end else begin
      phase_o     <= phase;
      indicator_o <= '0;
      case (mode_cur)
        2'b00: begin
          data_o      <= data_i[15:2];
          indicator_o <= 14'd8191;
        end
`ifdef KOVACS_SEQ_HOLD_EN
        2'b10: data_o <= data_o;
`endif
        default: data_o <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) done_o <= 1'b0;
    else       done_o <= (state == DONE);
  end

endmodule

// File: tb/tb_kovacs_sequencer.sv
// Directed bench for kovacs_sequencer; expected values are hand-derived from the protocol timing.
module tb_kovacs_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stop_i;
  logic [15:0] data_i;
  logic [31:0] T0_i, T1_i, T2_i, T3_i;
  logic [7:0]  mode_i;
  logic [1:0]  n_phases_i;
  logic [15:0] n_cycles_i;
  logic [13:0] data_o, indicator_o;
  logic [1:0]  phase_o, state_o;
  logic        busy_o, done_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [13:0] exp_q[$];

  kovacs_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .start_i(start_i), .stop_i(stop_i),
    .T0_i(T0_i), .T1_i(T1_i), .T2_i(T2_i), .T3_i(T3_i), .mode_i(mode_i),
    .n_phases_i(n_phases_i), .n_cycles_i(n_cycles_i), .data_o(data_o),
    .indicator_o(indicator_o), .phase_o(phase_o), .busy_o(busy_o), .done_o(done_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                           input logic [31:0] t3, input logic [7:0] mode, input logic [1:0] nph,
                           input logic [15:0] ncyc);
    T0_i = t0; T1_i = t1; T2_i = t2; T3_i = t3;
    mode_i = mode; n_phases_i = nph; n_cycles_i = ncyc;
  endtask

  // Start pulse, then step through ARM into the first RUN cycle.
  task automatic launch();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [13:0] exp_d;
    logic [13:0] hold_val;
    logic        done_seen;
    int          n;

    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; data_i = '0;
    configure(0, 0, 0, 0, 8'h00, 2'd0, 16'd0);
    tick(); tick();
    rst_i = 1'b0;
    check("rst_data", data_o, 0);
    check("rst_ind", indicator_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_state", state_o, 0);

    // Two cycles of pass(4) / zero(2)
    configure(3, 1, 0, 0, 8'h04, 2'd1, 16'd2);
    data_i = 16'h8004;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t2_arm_busy", busy_o, 1);
    check("t2_arm_state", state_o, 1);
    tick();
    check("t2_run0_data", data_o, 0);
    check("t2_run0_busy", busy_o, 1);
    for (int k = 0; k < 12; k++) exp_q.push_back((k % 6) < 4 ? 14'h2001 : 14'h0000);
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_d = exp_q.pop_front();
      check("t2_data", data_o, exp_d);
      check("t2_ind", indicator_o, ((k % 6) < 4) ? 14'd8191 : 14'd0);
      check("t2_phase", phase_o, ((k % 6) < 4) ? 2'd0 : 2'd1);
      check("t2_busy", busy_o, (k < 11) ? 1 : 0);
    end
    check("t2_done_state", state_o, 3);
    check("t2_done_early", done_o, 0);
    tick();
    check("t2_done_pulse", done_o, 1);
    check("t2_idle", state_o, 0);
    check("t2_data_after", data_o, 0);
    tick();
    check("t2_done_clear", done_o, 0);

    // Four one-cycle phases, alternating pass/zero
    configure(0, 0, 0, 0, 8'h44, 2'd3, 16'd1);
    data_i = 16'hFFFC;
    launch();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_phase", phase_o, i);
      check("t3_data", data_o, (i % 2 == 0) ? 14'h3FFF : 14'h0000);
    end
    check("t3_done_state", state_o, 3);
    tick();
    check("t3_done_pulse", done_o, 1);

    // Reset during phase 2
    configure(4, 4, 4, 4, 8'h00, 2'd3, 16'd0);
    data_i = 16'h1234;
    launch();
    repeat (11) tick();
    check("t1_phase_pre", phase_o, 2);
    check("t1_data_pre", data_o, 14'h048D);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t1_data", data_o, 0);
    check("t1_ind", indicator_o, 0);
    check("t1_phase", phase_o, 0);
    check("t1_busy", busy_o, 0);
    check("t1_state", state_o, 0);
    tick();
    check("t1_no_done", done_o, 0);

    // Infinite run, aborted by stop_i
    configure(5, 0, 0, 0, 8'h00, 2'd0, 16'd0);
    data_i = 16'h0008;
    launch();
    done_seen = 1'b0;
    repeat (100) begin
      tick();
      if (done_o) done_seen = 1'b1;
    end
    check("t4_no_done_run", done_seen, 0);
    check("t4_busy", busy_o, 1);
    check("t4_data", data_o, 14'd2);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("t4_stop_state", state_o, 0);
    check("t4_stop_busy", busy_o, 0);
    check("t4_stop_data", data_o, 0);
    check("t4_stop_ind", indicator_o, 0);
    tick();
    check("t4_stop_done", done_o, 0);

    // start and stop together in IDLE
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    check("t5_ss_state", state_o, 0);
    check("t5_ss_busy", busy_o, 0);
    tick();
    check("t5_ss_state2", state_o, 0);

    // T0 changed mid-run must not alter the period
    configure(3, 0, 0, 0, 8'h00, 2'd0, 16'd2);
    launch();
    T0_i = 32'd10;
    n = 0;
    while (!done_o && n < 50) begin
      tick();
      n++;
    end
    check("t5_period", n, 9);

    // Pass phase then hold (or zero) phase with ramping data
`ifdef KOVACS_SEQ_HOLD_EN
    hold_val = 14'd4;
`else
    hold_val = 14'd0;
`endif
    configure(3, 3, 0, 0, 8'h08, 2'd1, 16'd1);
    launch();
    for (int k = 0; k < 8; k++) exp_q.push_back(k < 4 ? 14'(k + 1) : hold_val);
    for (int k = 0; k < 8; k++) begin
      data_i = 16'((k + 1) << 2);
      tick();
      exp_d = exp_q.pop_front();
      check("t6_data", data_o, exp_d);
      check("t6_ind", indicator_o, (k < 4) ? 14'd8191 : 14'd0);
    end
    tick();
    check("t6_done", done_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
